// File: rtl/data_memory_handshake_pkg.sv
// Shared definitions for the data memory handshake slave.
// Contents: access-size encodings, read/write encoding, FSM state type
// and a helper that maps an access size to its byte count.
package data_memory_handshake_pkg;

  localparam logic [1:0] SSE_BYTE = 2'b00;
  localparam logic [1:0] SSE_HALF = 2'b01;
  localparam logic [1:0] SSE_WORD = 2'b10;

  localparam logic RW_READ = 1'b1;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte count of an access; the reserved encoding 11 behaves as a word.
  function automatic logic [2:0] sse_bytes(input logic [1:0] sse);
    case (sse)
      SSE_BYTE: sse_bytes = 3'd1;
      SSE_HALF: sse_bytes = 3'd2;
      default:  sse_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_handshake_mem_byte_array.sv
// Byte-wide storage with a 4-lane big-endian port at a base address.
// Lane i addresses byte base+i and maps to bits [31-8i -: 8].
// Ports:
//   clk    in  clock; writes occur on the rising edge
//   base   in  32-bit byte base address
//   we     in  per-lane write enables (lane 0 = byte at base)
//   wdata  in  write data, lane 0 in [31:24]
//   rdata  out combinational read data, lane 0 in [31:24]; lanes past DEPTH read 0
module mem_byte_array
  import data_memory_handshake_pkg::*;
#(
  parameter int unsigned DEPTH = 512
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] base,
  input  logic [LANES-1:0]  we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W:0]   lane_sum [LANES];
  logic [AW-1:0]     lane_idx [LANES];
  logic [LANES-1:0]  lane_ok;

  // Per-lane byte address, widened so base+3 can never wrap.
  always_comb begin
    rdata = '0;
    lane_ok = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum[i] = {1'b0, base} + (ADDR_W + 1)'(i);
      lane_ok[i]  = lane_sum[i] < (ADDR_W + 1)'(DEPTH);
      lane_idx[i] = lane_sum[i][AW-1:0];
      if (lane_ok[i]) rdata[DATA_W-1-8*i -: 8] = mem[lane_idx[i]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i] && lane_ok[i]) mem[lane_idx[i]] <= wdata[DATA_W-1-8*i -: 8];
    end
  end

endmodule

// File: rtl/data_memory_handshake.sv
// Byte-addressed data memory slave with an interlocked MOV/MOC handshake
// and WAIT_CYCLES wait states between request capture and access.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   MOV       in  memory operation valid
//   RW        in  1 = read, 0 = write
//   SSE       in  access size (00 byte, 01 half, 10/11 word)
//   addr      in  byte address
//   data_in   in  right-justified write data
//   data_out  out right-justified, zero-extended read data
//   MOC       out operation complete
//   ERR       out completed operation was rejected (misaligned / out of range)
//   busy      out FSM not in IDLE
module data_memory_handshake
  import data_memory_handshake_pkg::*;
#(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        SSE,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              MOC,
  output logic              ERR,
  output logic              busy
);

  localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cap_rw_q, cap_rw_d;
  logic [1:0]          cap_sse_q, cap_sse_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]   cap_data_q, cap_data_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                moc_q, moc_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic [2:0]          size_c;
  logic [ADDR_W:0]     end_addr_c;
  logic                acc_err_c;
  logic [LANES-1:0]    lane_we_c;
  logic [LANES-1:0]    mem_we_c;
  logic [DATA_W-1:0]   lane_wdata_c;
  logic [DATA_W-1:0]   mem_rdata_c;
  logic [DATA_W-1:0]   rd_steer_c;

  mem_byte_array #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .base  (cap_addr_q),
    .we    (mem_we_c),
    .wdata (lane_wdata_c),
    .rdata (mem_rdata_c)
  );

  // Alignment and range check on the captured request; 33-bit end address.
  always_comb begin
    size_c     = sse_bytes(cap_sse_q);
    end_addr_c = {1'b0, cap_addr_q} + (ADDR_W + 1)'(size_c) - (ADDR_W + 1)'(1);
    acc_err_c  = ((size_c == 3'd4) && (cap_addr_q[1:0] != 2'b00)) ||
                 ((size_c == 3'd2) && cap_addr_q[0]) ||
                 (end_addr_c >= (ADDR_W + 1)'(DEPTH));
  end

  // Steer right-justified data onto the big-endian lanes starting at lane 0.
  always_comb begin
    lane_we_c    = 4'b1111;
    lane_wdata_c = cap_data_q;
    rd_steer_c   = mem_rdata_c;
    case (cap_sse_q)
      SSE_BYTE: begin
        lane_we_c    = 4'b0001;
        lane_wdata_c = {cap_data_q[7:0], 24'h0};
        rd_steer_c   = {24'h0, mem_rdata_c[31:24]};
      end
      SSE_HALF: begin
        lane_we_c    = 4'b0011;
        lane_wdata_c = {cap_data_q[15:0], 16'h0};
        rd_steer_c   = {16'h0, mem_rdata_c[31:16]};
      end
      SSE_WORD: begin
        lane_we_c    = 4'b1111;
      end
      default: begin
        lane_we_c    = 4'b1111;
      end
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_rw_d   = cap_rw_q;
    cap_sse_d  = cap_sse_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    dout_d     = dout_q;
    moc_d      = moc_q;
    err_d      = err_q;
    mem_we_c   = '0;
    case (state_q)
      IDLE: begin
        if (MOV) begin
          cap_rw_d   = RW;
          cap_sse_d  = SSE;
          cap_addr_d = addr;
          cap_data_d = data_in;
          cnt_d      = CNT_W'(WAIT_CYCLES);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          moc_d   = 1'b1;
          err_d   = acc_err_c;
          if (!acc_err_c) begin
            if (cap_rw_q == RW_READ) dout_d   = rd_steer_c;
            else                     mem_we_c = lane_we_c;
          end
        end
      end
      DONE: begin
        if (!MOV) begin
          state_d = IDLE;
          moc_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        moc_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
    // Reset drops a write that would otherwise commit on this edge.
    if (reset) mem_we_c = '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cap_rw_q   <= 1'b0;
      cap_sse_q  <= 2'b00;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      dout_q     <= '0;
      moc_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_rw_q   <= cap_rw_d;
      cap_sse_q  <= cap_sse_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
      dout_q     <= dout_d;
      moc_q      <= moc_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out = dout_q;
  assign MOC      = moc_q;
  assign ERR      = err_q;
  assign busy     = busy_q;

endmodule
